// File: rtl/l2_resp_poll.sv
// L2 response poller: clocks filler bytes through the SPI PHY after an L3
// command and hands the first non-filler byte to the response checker.
module l2_resp_poll #(
    parameter int unsigned POLL_MAX  = 16,
    parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_l2_clr,
    input  logic       l3_en,
    input  logic       l3_cmd_done,
    output logic       tx_vld,
    output logic [7:0] tx_data,
    input  logic       tx_rdy,
    input  logic [7:0] rx_data,
    input  logic       rx_vld,
    output logic [7:0] resp,
    output logic       resp_vld,
    input  logic       resp_rdy,
    output logic       err_timeout,
    output logic [7:0] poll_cnt
);

    localparam logic [7:0] MAX_B = 8'(POLL_MAX);

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_SEND = 6'b000010,
        S_WAIT = 6'b000100,
        S_PRES = 6'b001000,
        S_HOLD = 6'b010000,
        S_TOUT = 6'b100000
    } state_t;

    state_t     r_state;
    logic [7:0] r_resp;
    logic [7:0] r_poll_cnt;
    logic       r_tx_vld;
    logic       r_resp_vld;
    logic       r_err;

    logic       w_is_fill;
    logic       w_sat;
    logic       w_last;
    logic [7:0] w_cnt_inc;
    logic [7:0] w_cnt_next;

    assign w_is_fill  = (rx_data == FILL_BYTE);
    assign w_sat      = (r_poll_cnt >= MAX_B);
    assign w_cnt_inc  = r_poll_cnt + 8'd1;
    assign w_cnt_next = w_sat ? MAX_B : w_cnt_inc;
    assign w_last     = w_sat || (w_cnt_inc == MAX_B);

    // Outputs are registered alongside the state so nothing leaks
    // combinationally from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_resp     <= '0;
            r_poll_cnt <= '0;
            r_tx_vld   <= 1'b0;
            r_resp_vld <= 1'b0;
            r_err      <= 1'b0;
        end else if (pin_l2_clr) begin
            r_state    <= S_IDLE;
            r_resp     <= '0;
            r_poll_cnt <= '0;
            r_tx_vld   <= 1'b0;
            r_resp_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (l3_en) begin
                        r_state    <= S_SEND;
                        r_tx_vld   <= 1'b1;
                        r_poll_cnt <= '0;
                    end
                end
                S_SEND: begin
                    if (l3_cmd_done) begin
                        r_state  <= S_IDLE;
                        r_tx_vld <= 1'b0;
                    end else if (tx_rdy) begin
                        r_state  <= S_WAIT;
                        r_tx_vld <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (l3_cmd_done) begin
                        r_state <= S_IDLE;
                    end else if (rx_vld) begin
                        if (w_is_fill) begin
                            r_poll_cnt <= w_cnt_next;
                            if (w_last) begin
                                r_state <= S_TOUT;
                                r_err   <= 1'b1;
                            end else begin
                                r_state  <= S_SEND;
                                r_tx_vld <= 1'b1;
                            end
                        end else begin
                            r_resp     <= rx_data;
                            r_state    <= S_PRES;
                            r_resp_vld <= 1'b1;
                        end
                    end
                end
                S_PRES: begin
                    if (l3_cmd_done) begin
                        r_state    <= S_IDLE;
                        r_resp_vld <= 1'b0;
                    end else if (resp_rdy) begin
                        r_state    <= S_HOLD;
                        r_resp_vld <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (l3_cmd_done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_TOUT: begin
                    if (l3_cmd_done) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_vld   <= 1'b0;
                    r_resp_vld <= 1'b0;
                    r_err      <= 1'b0;
                end
            endcase
        end
    end

    assign tx_vld      = r_tx_vld;
    assign tx_data     = FILL_BYTE;
    assign resp        = r_resp;
    assign resp_vld    = r_resp_vld;
    assign err_timeout = r_err;
    assign poll_cnt    = r_poll_cnt;

endmodule
